// File: rtl/tap_deck_ctrl.sv
// Tape-deck controller: shares the tape RAM between host loader and player, and sequences play/stop/rewind/gap.
// Optional build macro TAP_LOOP_EN: at end of image, rewind and keep playing instead of entering DONE.
module tap_deck_ctrl #(
  parameter int unsigned GAP_CYCLES = 3500000,
  parameter int unsigned GAP_W      = 22
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        btn_play,
  input  logic        btn_stop,
  input  logic        btn_rewind,
  input  logic        host_req,
  input  logic [15:0] host_addr,
  input  logic [7:0]  host_wdata,
  input  logic        host_clear,
  output logic        host_ack,
  input  logic [15:0] player_addr,
  output logic [7:0]  player_data,
  input  logic        block_done,
  output logic        player_play,
  output logic        player_rewind,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_we,
  input  logic [7:0]  mem_rdata,
  output logic [15:0] image_len,
  output logic [1:0]  deck_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_GAP  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES - 1);

  state_e             state_q, state_d;
  logic               play_q, play_d;
  logic               rewind_q, rewind_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic [15:0]        len_q, len_d;

  logic               host_open;
  logic [16:0]        wr_len17;
  logic [15:0]        wr_len;
  logic [15:0]        len_base;

  // The host owns the RAM only while the player is parked (IDLE or DONE).
  always_comb begin
    host_open   = (state_q == S_IDLE) || (state_q == S_DONE);
    host_ack    = host_req & host_open;
    mem_we      = host_ack;
    mem_addr    = host_ack ? host_addr : player_addr;
    mem_wdata   = host_wdata;
    player_data = mem_rdata;
  end

  // Clear is applied first, so a same-cycle write leaves image_len = host_addr+1.
  always_comb begin
    wr_len17 = {1'b0, host_addr} + 17'd1;
    wr_len   = wr_len17[16] ? 16'hFFFF : wr_len17[15:0];
    len_base = (host_clear && host_open) ? 16'd0 : len_q;
    len_d    = len_base;
    if (host_ack && (wr_len > len_base)) begin
      len_d = wr_len;
    end
  end

  always_comb begin
    state_d  = state_q;
    play_d   = play_q;
    rewind_d = 1'b0;
    gap_d    = gap_q;
    if (btn_rewind) begin
      rewind_d = 1'b1;
      play_d   = 1'b0;
      state_d  = S_IDLE;
    end else if (btn_stop) begin
      // A stop consumes the cycle; it only has an effect while playing.
      if ((state_q == S_RUN) || (state_q == S_GAP)) begin
        play_d  = 1'b0;
        state_d = S_IDLE;
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          if (btn_play && (len_q != 16'd0)) begin
            play_d  = 1'b1;
            state_d = S_RUN;
          end
        end
        S_DONE: begin
          if (btn_play) begin
            rewind_d = 1'b1;
            play_d   = 1'b1;
            state_d  = S_RUN;
          end
        end
        S_RUN: begin
          if (block_done) begin
            play_d  = 1'b0;
            gap_d   = GAP_LOAD;
            state_d = S_GAP;
          end
        end
        S_GAP: begin
          if (gap_q == '0) begin
            if (player_addr >= len_q) begin
`ifdef TAP_LOOP_EN
              rewind_d = 1'b1;
              play_d   = 1'b1;
              state_d  = S_RUN;
`else
              play_d   = 1'b0;
              state_d  = S_DONE;
`endif
            end else begin
              play_d  = 1'b1;
              state_d = S_RUN;
            end
          end else begin
            gap_d = gap_q - 1'b1;
          end
        end
        default: begin
          play_d  = 1'b0;
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      play_q   <= 1'b0;
      rewind_q <= 1'b0;
      gap_q    <= '0;
      len_q    <= 16'd0;
    end else begin
      state_q  <= state_d;
      play_q   <= play_d;
      rewind_q <= rewind_d;
      gap_q    <= gap_d;
      len_q    <= len_d;
    end
  end

  assign player_play   = play_q;
  assign player_rewind = rewind_q;
  assign image_len     = len_q;
  assign deck_state    = state_q;

endmodule
